video_cfg_ctrl: RTL

Single-clock control block in the video subsystem. It decodes MCU configuration commands from the SPI byte stream into the user video settings (scanlines, volume, wide screen). It also sequences the HDMI PLL reset: it asserts hdmi_pll_reset at power-up, on a video-mode change, on a wide-screen change or on MCU request, then waits for lock. It drives the settings into the video top and reports video_ready once the HDMI pixel clock is stable.

---
 rtl/video_cfg_pkg.sv | 51 +++++
 rtl/pll_reset_seq.sv | 127 ++++++++++++
 rtl/video_cfg_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/video_cfg_pkg.sv
// Shared definitions for the video configuration controller: MCU command
// codes, video-mode encodings, FSM state types and the settings bundle.
package video_cfg_pkg;

  // MCU command bytes (first byte after mcu_start)
  localparam logic [7:0] CMD_SCANLINES = 8'h01;
  localparam logic [7:0] CMD_VOLUME    = 8'h02;
  localparam logic [7:0] CMD_WIDE      = 8'h03;
  localparam logic [7:0] CMD_PLL_RESET = 8'h04;

  // Video analyzer mode encodings
  localparam logic [1:0] VMODE_PAL  = 2'd0;
  localparam logic [1:0] VMODE_NTSC = 2'd1;
  localparam logic [1:0] VMODE_MONO = 2'd2;

  // MCU byte-stream parser states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    ARG  = 2'd2,
    SKIP = 2'd3
  } parser_state_e;

  // HDMI PLL reset sequencer states
  typedef enum logic [1:0] {
    RST_ASSERT = 2'd0,
    WAIT_LOCK  = 2'd1,
    SETTLE     = 2'd2,
    RUN        = 2'd3
  } seq_state_e;

  // User video settings as driven into the video top
  typedef struct packed {
    logic [1:0] scanlines;
    logic [1:0] volume;
    logic       wide;
  } video_settings_t;

  // True for commands that carry one argument byte
  function automatic logic is_setting_cmd(input logic [7:0] code);
    return (code == CMD_SCANLINES) || (code == CMD_VOLUME) || (code == CMD_WIDE);
  endfunction

  // Largest of three counts, used to size the shared sequencer counter
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_reset_seq.sv
// HDMI PLL reset sequencer: holds the PLL in reset, waits for lock with a
// timeout, requires lock to stay stable for a settle period, then reports
// video_ready. Any retrigger restarts the whole sequence.
module pll_reset_seq
  import video_cfg_pkg::*;
#(
  parameter int RST_CYCLES    = 64,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int SETTLE_CYCLES = 1024
) (
  input  logic clk,
  input  logic resetn,
  input  logic force_i,
  input  logic retrigger_i,
  input  logic pll_lock_i,
  output logic hdmi_pll_reset_o,
  output logic video_ready_o
);

  // One counter serves all timed states; it is cleared on every state change,
  // so it only ever needs to hold the largest terminal count.
  localparam int CNT_W = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES));

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lock_meta_q, lock_s_q;
  logic             hdmi_pll_reset_q, hdmi_pll_reset_d;
  logic             video_ready_q, video_ready_d;
  logic             restart;

  // Two-flop synchronizer bringing pll_lock into the clk domain
  // NOTE: sequential state is always written with non-blocking assignments so
  // every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= pll_lock_i;
      lock_s_q    <= lock_meta_q;
    end
  end

  // Losing lock while running is treated like any other retrigger
  assign restart = force_i || retrigger_i || ((state_q == RUN) && !lock_s_q);

  // State register, counter and registered (glitch-free) outputs
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q          <= RST_ASSERT;
      cnt_q            <= '0;
      hdmi_pll_reset_q <= 1'b1;
      video_ready_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      hdmi_pll_reset_q <= hdmi_pll_reset_d;
      video_ready_q    <= video_ready_d;
    end
  end

  // Next-state and counter logic
  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (restart) begin
      state_d = RST_ASSERT;
      cnt_d   = '0;
    end else begin
      case (state_q)
        RST_ASSERT: begin
          if (cnt_q == RST_LAST) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        WAIT_LOCK: begin
          if (lock_s_q) begin
            state_d = SETTLE;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_d = RST_ASSERT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        SETTLE: begin
          if (!lock_s_q) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == SETTLE_LAST) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        RUN: begin
          cnt_d = '0;
        end
        default: begin
          state_d = RST_ASSERT;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output decode from the next state so both outputs switch on the same edge
  always_comb begin
    hdmi_pll_reset_d = (state_d == RST_ASSERT);
    video_ready_d    = (state_d == RUN);
  end

  assign hdmi_pll_reset_o = hdmi_pll_reset_q;
  assign video_ready_o    = video_ready_q;

endmodule

// File: rtl/video_cfg_ctrl.sv
// Video configuration controller: parses MCU command bytes into the user
// video settings and drives the HDMI PLL reset sequencer from mode changes,
// wide-screen changes and explicit MCU requests.
module video_cfg_ctrl
  import video_cfg_pkg::*;
#(
  parameter int         RST_CYCLES     = 64,
  parameter int         LOCK_TIMEOUT   = 65536,
  parameter int         SETTLE_CYCLES  = 1024,
  parameter logic [1:0] DEFAULT_VOLUME = 2'd3
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       mcu_start,
  input  logic       mcu_strobe,
  input  logic [7:0] mcu_data,
  input  logic [1:0] vmode,
  input  logic       pll_lock,
  output logic [1:0] system_scanlines,
  output logic [1:0] system_volume,
  output logic       system_wide_screen,
  output logic       hdmi_pll_reset,
  output logic       video_ready,
  output logic       cfg_update
);

  parser_state_e   pstate_q, pstate_d;
  logic [7:0]      cmd_q, cmd_d;
  video_settings_t set_q, set_d;
  logic            cfg_update_q, cfg_update_d;
  logic            wide_chg_q, wide_chg_d;
  logic            force_q, force_d;
  logic [1:0]      vmode_q;
  logic            byte_ok;
  logic            retrigger;

  // A strobe coinciding with mcu_start belongs to no transaction and is dropped
  assign byte_ok = mcu_strobe && !mcu_start;

  // Parser state and latched command byte
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pstate_q <= IDLE;
      cmd_q    <= '0;
    end else begin
      pstate_q <= pstate_d;
      cmd_q    <= cmd_d;
    end
  end

  // Parser next-state: start always re-arms, then command, argument, skip
  always_comb begin
    pstate_d = pstate_q;
    cmd_d    = cmd_q;
    if (mcu_start) begin
      pstate_d = CMD;
    end else begin
      case (pstate_q)
        IDLE, SKIP: ;
        CMD: begin
          if (mcu_strobe) begin
            cmd_d    = mcu_data;
            pstate_d = is_setting_cmd(mcu_data) ? ARG : SKIP;
          end
        end
        ARG: begin
          if (mcu_strobe) pstate_d = SKIP;
        end
        default: pstate_d = IDLE;
      endcase
    end
  end

  // Parser outputs: setting writes, force request and change detection
  always_comb begin
    set_d   = set_q;
    force_d = 1'b0;
    if (byte_ok) begin
      if ((pstate_q == CMD) && (mcu_data == CMD_PLL_RESET)) force_d = 1'b1;
      if (pstate_q == ARG) begin
        case (cmd_q)
          CMD_SCANLINES: set_d.scanlines = mcu_data[1:0];
          CMD_VOLUME:    set_d.volume    = mcu_data[1:0];
          CMD_WIDE:      set_d.wide      = mcu_data[0];
          default: ;
        endcase
      end
    end
    cfg_update_d = (set_d != set_q);
    wide_chg_d   = (set_d.wide != set_q.wide);
  end

  // Settings register, change pulses and previous-vmode tracking
  always_ff @(posedge clk) begin
    if (!resetn) begin
      set_q        <= '{scanlines: 2'd0, volume: DEFAULT_VOLUME, wide: 1'b0};
      cfg_update_q <= 1'b0;
      wide_chg_q   <= 1'b0;
      force_q      <= 1'b0;
      // Track the live mode during reset so leaving reset is not seen as a change
      vmode_q      <= vmode;
    end else begin
      set_q        <= set_d;
      cfg_update_q <= cfg_update_d;
      wide_chg_q   <= wide_chg_d;
      force_q      <= force_d;
      vmode_q      <= vmode;
    end
  end

  // The wide pulse is aligned with the new output value, so the sequencer
  // reacts one edge after system_wide_screen changes.
  assign retrigger = wide_chg_q || (vmode != vmode_q);

  pll_reset_seq #(
    .RST_CYCLES    (RST_CYCLES),
    .LOCK_TIMEOUT  (LOCK_TIMEOUT),
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_pll_reset_seq (
    .clk              (clk),
    .resetn           (resetn),
    .force_i          (force_q),
    .retrigger_i      (retrigger),
    .pll_lock_i       (pll_lock),
    .hdmi_pll_reset_o (hdmi_pll_reset),
    .video_ready_o    (video_ready)
  );

  assign system_scanlines   = set_q.scanlines;
  assign system_volume      = set_q.volume;
  assign system_wide_screen = set_q.wide;
  assign cfg_update         = cfg_update_q;

endmodule
